serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Drives a single 1-bit full-adder cell once per cycle, LSB first, holding the carry between cycles.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between an operand producer and a result consumer; trades latency for area against a ripple adder.

---
 rtl/serial_add_pkg.sv | 21 ++
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The unused encoding 2'd3 is treated as IDLE so a corrupted state recovers.
  function automatic state_t decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    return RUN;
      2'd2:    return DONE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder cell, purely combinational; the controller reuses it once per bit.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts operands, adds one bit per cycle LSB first through
// a single full-adder cell, then presents the sum and carry-out until the consumer takes them.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_cin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_cout,
  input  logic             io_flush,
  output logic             io_busy
);

  logic [1:0]       state_q;
  state_t           st;
  state_t           next_st;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             cell_sum;
  logic             cell_cout;
  logic             accept;
  logic             last_bit;

  assign st       = decode_state(state_q);
  assign accept   = io_in_valid & io_in_ready;
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  serial_fa_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (cell_sum),
    .cout(cell_cout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= next_st;
  end

  always_comb begin
    next_st = st;
    if (io_flush) begin
      next_st = IDLE;
    end else begin
      case (st)
        IDLE:    if (accept) next_st = RUN;
        RUN:     if (last_bit) next_st = DONE;
        DONE:    if (io_out_ready) next_st = IDLE;
        default: next_st = IDLE;
      endcase
    end
  end

  // Operand shift registers, sum accumulator and carry; new sum bits enter at the MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (io_flush) begin
      carry <= 1'b0;
      count <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (accept) begin
            a_sh  <= io_in_a;
            b_sh  <= io_in_b;
            carry <= io_in_cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= (sum_sh >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
          carry  <= cell_cout;
          count  <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Ready is masked by reset so nothing is offered while reset is held.
  always_comb begin
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_busy      = 1'b0;
    io_out_sum   = '0;
    io_out_cout  = 1'b0;
    case (st)
      IDLE: io_in_ready = reset;
      RUN:  io_busy = 1'b1;
      DONE: begin
        io_busy      = 1'b1;
        io_out_valid = 1'b1;
        io_out_sum   = sum_sh;
        io_out_cout  = carry;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances checked every cycle against a
// transaction-level model (arithmetic result plus a latency countdown).
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       in_valid[2];
  logic       out_ready[2];
  logic       flush[2];
  logic       cin[2];
  logic [7:0] a[2];
  logic [7:0] b[2];

  logic       rdy8, vld8, cout8, busy8;
  logic [7:0] sum8;
  logic       rdy1, vld1, cout1, busy1;
  logic [0:0] sum1;

  int         W[2] = '{8, 1};
  int         ph[2];
  int         left[2];
  int         nops[2];
  logic [8:0] res[2];

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst_n),
    .io_in_valid(in_valid[0]), .io_in_ready(rdy8),
    .io_in_a(a[0]), .io_in_b(b[0]), .io_in_cin(cin[0]),
    .io_out_valid(vld8), .io_out_ready(out_ready[0]),
    .io_out_sum(sum8), .io_out_cout(cout8),
    .io_flush(flush[0]), .io_busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clock(clk), .reset(rst_n),
    .io_in_valid(in_valid[1]), .io_in_ready(rdy1),
    .io_in_a(a[1][0:0]), .io_in_b(b[1][0:0]), .io_in_cin(cin[1]),
    .io_out_valid(vld1), .io_out_ready(out_ready[1]),
    .io_out_sum(sum1), .io_out_cout(cout1),
    .io_flush(flush[1]), .io_busy(busy1)
  );

  function automatic logic [7:0] mask(input int k);
    return (k == 0) ? 8'hFF : 8'h01;
  endfunction

  function logic f_rdy(input int k);
    return (k == 0) ? rdy8 : rdy1;
  endfunction
  function logic f_vld(input int k);
    return (k == 0) ? vld8 : vld1;
  endfunction
  function logic f_cout(input int k);
    return (k == 0) ? cout8 : cout1;
  endfunction
  function logic f_busy(input int k);
    return (k == 0) ? busy8 : busy1;
  endfunction
  function logic [7:0] f_sum(input int k);
    return (k == 0) ? sum8 : {7'b0, sum1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: phase 0 = waiting for operands, 1 = computing (WIDTH cycles), 2 = result held.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] <= 0;
      end else if (flush[k]) begin
        ph[k] <= 0;
      end else begin
        case (ph[k])
          0: if (in_valid[k]) begin
            res[k]  <= {1'b0, a[k] & mask(k)} + {1'b0, b[k] & mask(k)} + {8'b0, cin[k]};
            left[k] <= W[k];
            ph[k]   <= 1;
          end
          1: begin
            left[k] <= left[k] - 1;
            if (left[k] == 1) ph[k] <= 2;
          end
          default: if (out_ready[k]) begin
            ph[k]   <= 0;
            nops[k] <= nops[k] + 1;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp_in_ready_w%0d", W[k]), 32'(f_rdy(k)), 32'(rst_n && ph[k] == 0));
        chk($sformatf("cmp_out_valid_w%0d", W[k]), 32'(f_vld(k)), 32'(ph[k] == 2));
        chk($sformatf("cmp_busy_w%0d", W[k]), 32'(f_busy(k)), 32'(ph[k] != 0));
        chk($sformatf("cmp_sum_w%0d", W[k]), 32'(f_sum(k)),
            32'((ph[k] == 2) ? (res[k][7:0] & mask(k)) : 8'h00));
        chk($sformatf("cmp_cout_w%0d", W[k]), 32'(f_cout(k)),
            32'((ph[k] == 2) ? res[k][W[k]] : 1'b0));
      end
    end
  end

  task automatic do_op(input int k, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input int elat);
    int cyc;
    cyc = 0;
    while (!f_rdy(k) && cyc < 50) begin
      step();
      cyc++;
    end
    chk("op_in_ready", 32'(f_rdy(k)), 32'd1);
    in_valid[k] = 1'b1;
    a[k] = ia;
    b[k] = ib;
    cin[k] = ic;
    step();
    in_valid[k] = 1'b0;
    a[k] = 8'($urandom);
    b[k] = 8'($urandom);
    cin[k] = 1'($urandom);
    cyc = 0;
    while (!f_vld(k) && cyc < 100) begin
      step();
      cyc++;
    end
    chk("op_latency", 32'(cyc), 32'(elat));
    chk("op_sum", 32'(f_sum(k)), 32'(es));
    chk("op_cout", 32'(f_cout(k)), 32'(ec));
    if (out_ready[k]) begin
      step();
      chk("op_ready_after", 32'(f_rdy(k)), 32'd1);
      chk("op_valid_after", 32'(f_vld(k)), 32'd0);
    end
  endtask

  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib);
    in_valid[0] = 1'b1;
    a[0] = ia;
    b[0] = ib;
    cin[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
  endtask

  initial begin
    int cycles;
    int base;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      flush[k] = 1'b0;
      cin[k] = 1'b0;
      a[k] = 8'h00;
      b[k] = 8'h00;
    end

    #1 rst_n = 1'b0;
    started = 1;
    #2;
    chk("rst_in_ready", 32'(rdy8), 32'd0);
    chk("rst_out_valid", 32'(vld8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(rdy8), 32'd1);

    do_op(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8);
    do_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
    do_op(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8);
    do_op(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8);

    // Backpressure: result must hold and new requests must be refused.
    out_ready[0] = 1'b0;
    do_op(0, 8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'(i % 2);
      a[0] = 8'($urandom);
      b[0] = 8'($urandom);
      step();
      chk("bp_sum_stable", 32'(sum8), 32'h46);
      chk("bp_in_ready", 32'(rdy8), 32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    step();
    chk("bp_release_valid", 32'(vld8), 32'd0);
    chk("bp_release_ready", 32'(rdy8), 32'd1);

    // Flush at count 3.
    start_op(8'h55, 8'h22);
    step();
    step();
    step();
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("flush_ready", 32'(rdy8), 32'd1);
    chk("flush_busy", 32'(busy8), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("flush_no_valid", 32'(vld8), 32'd0);
    end
    do_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8);

    // Reset at count 5.
    start_op(8'h77, 8'h11);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(rdy8), 32'd0);
    chk("midrst_out_valid", 32'(vld8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    step();
    rst_n = 1'b1;
    do_op(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8);

    do_op(1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1);
    do_op(1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1);

    cycles = 0;
    base = nops[0];
    while ((nops[0] - base) < 1000 && cycles < 60000) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        a[k] = 8'($urandom);
        b[k] = 8'($urandom);
        cin[k] = 1'($urandom);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        flush[k] = ($urandom_range(0, 63) == 0);
      end
      step();
      cycles++;
    end
    chk("random_ops_completed", 32'((nops[0] - base) >= 1000), 32'd1);
    chk("random_w1_ops_seen", 32'(nops[1] > 100), 32'd1);
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      flush[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
